// File: rtl/mealy_serial_feeder.sv
// Word-to-serial feeder: accepts parallel words on a valid/ready handshake and shifts them out
// one bit per clock. Define FEEDER_LSB_FIRST_EN to send LSB-first instead of MSB-first.
module mealy_serial_feeder #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_data,
    input  logic [LEN_W-1:0] word_len,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             in_data,
    output logic             bit_valid,
    output logic             done,
    output logic             busy,
    output logic [15:0]      word_cnt,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a word transfers on a rising edge where word_valid && word_ready; word_ready
    // depends only on state and bit counter, and valid while ready is low is simply ignored.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [3:0]       GAP_L   = 4'(GAP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [LEN_W-1:0] r_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_in_data;
    logic             r_bit_valid;
    logic [15:0]      r_word_cnt;

    logic [LEN_W-1:0] w_len_eff;
    logic [WIDTH-1:0] w_load;
    logic             w_first_bit;
    logic             w_last;
    logic             w_accept;

    assign w_len_eff = ((word_len == '0) || (word_len > WIDTH_L)) ? WIDTH_L : word_len;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == LEN_W'(1));
    assign w_accept  = word_valid && word_ready;

`ifdef FEEDER_LSB_FIRST_EN
    assign w_first_bit = word_data[0];
    assign w_load      = word_data >> 1;
`else
    // Left-align the word so the first bit to send always sits at the top of the register.
    logic [WIDTH-1:0] w_align;
    assign w_align     = word_data << (WIDTH_L - w_len_eff);
    assign w_first_bit = w_align[WIDTH-1];
    assign w_load      = w_align << 1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                    end else if (w_accept) begin
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        word_ready  = (r_state == S_IDLE) || ((GAP == 0) && w_last);
        done        = w_last;
        busy        = (r_state != S_IDLE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_in_data   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_in_data   <= 1'b0;
            r_bit_valid <= 1'b0;
            if (w_accept) begin
                r_shift     <= w_load;
                r_cnt       <= w_len_eff;
                r_in_data   <= w_first_bit;
                r_bit_valid <= 1'b1;
            end else if ((r_state == S_SHIFT) && !w_last) begin
`ifdef FEEDER_LSB_FIRST_EN
                r_in_data <= r_shift[0];
                r_shift   <= r_shift >> 1;
`else
                r_in_data <= r_shift[WIDTH-1];
                r_shift   <= r_shift << 1;
`endif
                r_cnt       <= r_cnt - LEN_W'(1);
                r_bit_valid <= 1'b1;
            end else if (w_last) begin
                r_cnt <= '0;
            end

            if (w_last) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end

            // The gap counter is loaded on the last bit and counts the forced idle cycles down.
            if (w_last && (GAP > 0)) begin
                r_gap_cnt <= GAP_L;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    assign in_data   = r_in_data;
    assign bit_valid = r_bit_valid;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_mealy_serial_feeder.sv
// Bench for mealy_serial_feeder: one GAP=0 and one GAP=2 instance checked every cycle
// against a bit-stream reference model, plus directed literal checks of the serial patterns.
module tb_mealy_serial_feeder;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [WIDTH-1:0] word_data = '0;
  logic [LEN_W-1:0] word_len = '0;
  logic v0 = 1'b0, v2 = 1'b0;

  logic wr0, id0, bv0, dn0, bz0, wr2, id2, bv2, dn2, bz2;
  logic [15:0] wc0, wc2;
  logic [1:0] st0, st2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mealy_serial_feeder #(.WIDTH(WIDTH), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .word_data(word_data), .word_len(word_len), .word_valid(v0),
    .word_ready(wr0), .in_data(id0), .bit_valid(bv0), .done(dn0), .busy(bz0),
    .word_cnt(wc0), .o_dbg_state(st0)
  );

  mealy_serial_feeder #(.WIDTH(WIDTH), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .word_data(word_data), .word_len(word_len), .word_valid(v2),
    .word_ready(wr2), .in_data(id2), .bit_valid(bv2), .done(dn2), .busy(bz2),
    .word_cnt(wc2), .o_dbg_state(st2)
  );

  // Reference model: the current bit on the line plus the remaining bits in send order.
  int          gap_of [2];
  logic        m_cur_v [2];
  logic        m_cur_b [2];
  logic        m_cur_last [2];
  logic [31:0] m_rem [2];
  int          m_rem_n [2];
  int          m_gap [2];
  logic [15:0] m_cnt [2];
  logic        m_acc [2];

  logic [31:0] col0;
  int          ncol0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input int i);
    return (!m_cur_v[i] && m_gap[i] == 0) || (gap_of[i] == 0 && m_cur_v[i] && m_cur_last[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur_v[i] = 0; m_cur_b[i] = 0; m_cur_last[i] = 0;
      m_rem[i] = '0; m_rem_n[i] = 0; m_gap[i] = 0; m_cnt[i] = '0; m_acc[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic vld, input logic [7:0] d,
                            input logic [3:0] l);
    int L;
    logic [31:0] order;
    logic ending;
    m_acc[i] = vld && model_ready(i);
    ending = m_cur_v[i] && m_cur_last[i];
    if (ending) m_cnt[i] = m_cnt[i] + 16'd1;
    if (m_gap[i] > 0) m_gap[i]--;
    if (ending && gap_of[i] > 0) m_gap[i] = gap_of[i];
    if (m_acc[i]) begin
      L = (l == 0 || l > WIDTH) ? WIDTH : int'(l);
      order = '0;
      for (int k = 0; k < L; k++) begin
`ifdef FEEDER_LSB_FIRST_EN
        order[k] = d[k];
`else
        order[k] = d[L-1-k];
`endif
      end
      m_cur_v[i] = 1; m_cur_b[i] = order[0];
      m_rem[i] = order >> 1; m_rem_n[i] = L - 1;
      m_cur_last[i] = (L == 1);
    end else if (m_cur_v[i] && !m_cur_last[i]) begin
      m_cur_b[i] = m_rem[i][0];
      m_rem[i] = m_rem[i] >> 1;
      m_rem_n[i]--;
      m_cur_last[i] = (m_rem_n[i] == 0);
    end else begin
      m_cur_v[i] = 0; m_cur_b[i] = 0; m_cur_last[i] = 0;
    end
  endtask

  task automatic check_all();
    logic r, d, v, dn, bz;
    logic [15:0] wc;
    string s;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin r = wr0; d = id0; v = bv0; dn = dn0; bz = bz0; wc = wc0; end
      else        begin r = wr2; d = id2; v = bv2; dn = dn2; bz = bz2; wc = wc2; end
      s = (i == 0) ? "g0" : "g2";
      chk({s, "_ready"},  32'(r),  32'(model_ready(i)));
      chk({s, "_in_data"}, 32'(d), 32'(m_cur_v[i] && m_cur_b[i]));
      chk({s, "_bit_valid"}, 32'(v), 32'(m_cur_v[i]));
      chk({s, "_done"},   32'(dn), 32'(m_cur_v[i] && m_cur_last[i]));
      chk({s, "_busy"},   32'(bz), 32'(m_cur_v[i] || m_gap[i] > 0));
      chk({s, "_word_cnt"}, 32'(wc), 32'(m_cnt[i]));
    end
    if (bv0) begin
      col0 = {col0[30:0], id0};
      ncol0++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_step(0, v0, word_data, word_len);
      model_step(1, v2, word_data, word_len);
    end else begin
      model_reset();
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [3:0] l, input bit keep);
    bit got;
    got = 0;
    word_data = d; word_len = l;
    if (i == 0) v0 = 1'b1; else v2 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (m_acc[i]) begin
        got = 1;
        break;
      end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    if (!keep) begin
      if (i == 0) v0 = 1'b0; else v2 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_reset_now();
    chk("rst_in_data",   32'({id0, id2}), 32'd0);
    chk("rst_bit_valid", 32'({bv0, bv2}), 32'd0);
    chk("rst_done",      32'({dn0, dn2}), 32'd0);
    chk("rst_busy",      32'({bz0, bz2}), 32'd0);
    chk("rst_word_cnt",  {wc0, wc2}, 32'd0);
    chk("rst_ready",     32'({wr0, wr2}), 32'd3);
  endtask

  initial begin
    gap_of[0] = 0;
    gap_of[1] = 2;
    model_reset();
    col0 = '0;
    ncol0 = 0;

    // Reset, with a word offered that must not be captured.
    v0 = 1'b1; word_data = 8'hFF; word_len = 4'd8;
    #1;
    check_reset_now();
    idle(3);
    v0 = 1'b0;
    rst = 1'b1;
    idle(2);

    // Single 5-bit word.
    col0 = '0; ncol0 = 0;
    send(0, 8'b0001_0110, 4'd5, 0);
    idle(7);
    chk("single_nbits", 32'(ncol0), 32'd5);
`ifdef FEEDER_LSB_FIRST_EN
    chk("single_stream", col0 & 32'h1F, 32'b01101);
`else
    chk("single_stream", col0 & 32'h1F, 32'b10110);
`endif
    chk("single_cnt", 32'(wc0), 32'd1);

    // Back-to-back words held valid.
    col0 = '0; ncol0 = 0;
    send(0, 8'b0001_0110, 4'd5, 1);
    send(0, 8'b0001_0110, 4'd5, 0);
    idle(7);
    chk("b2b_nbits", 32'(ncol0), 32'd10);
    chk("b2b_cnt", 32'(wc0), 32'd3);

    // Forced gap on the GAP=2 instance.
    send(1, 8'b0000_0101, 4'd3, 1);
    send(1, 8'b0000_0101, 4'd3, 0);
    idle(8);

    // Length clamp: 0 and 15 both mean 8 bits; A5 reads the same in either order.
    col0 = '0; ncol0 = 0;
    send(0, 8'hA5, 4'd0, 0);
    idle(9);
    send(0, 8'hA5, 4'd15, 0);
    idle(9);
    chk("clamp_nbits", 32'(ncol0), 32'd16);
    chk("clamp_stream", col0 & 32'hFFFF, 32'hA5A5);
    send(1, 8'h3C, 4'd0, 0);
    idle(12);

    // Randomized traffic on both instances.
    for (int n = 0; n < 40; n++) begin
      send($urandom_range(0, 1), 8'($urandom), 4'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
      v0 = 1'b0; v2 = 1'b0;
      idle($urandom_range(0, 2));
    end
    idle(14);

    // Asynchronous reset in the middle of a word, away from any clock edge.
    send(0, 8'hC3, 4'd8, 0);
    send(1, 8'h5A, 4'd8, 0);
    idle(1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_now();
    model_reset();
    idle(2);
    rst = 1'b1;
    col0 = '0; ncol0 = 0;
    send(0, 8'h96, 4'd8, 0);
    idle(10);
    chk("after_rst_nbits", 32'(ncol0), 32'd8);
`ifdef FEEDER_LSB_FIRST_EN
    chk("after_rst_stream", col0 & 32'hFF, 32'h69);
`else
    chk("after_rst_stream", col0 & 32'hFF, 32'h96);
`endif
    chk("after_rst_cnt", 32'(wc0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
